seq_mag_comp: RTL
=================

SEQ_MAG_COMP -- requirements
Module: seq_mag_comp

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 4, bits compared per clock; SHALL be ≥1 and ≤WIDTH.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset; synchronous and active-low.
REQ-005 Port start  input  1  request a comparison; sampled only in IDLE.
REQ-006 Port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-007 Port a  input  WIDTH  operand A; sampled with start.
REQ-008 Port b  input  WIDTH  operand B; sampled with start.
REQ-009 Port busy  output  1  high while a comparison is in progress.
REQ-010 Port done  output  1  one-cycle pulse; result valid.
REQ-011 Port gt  output  1  A > B.
REQ-012 Port eq  output  1  A == B.
REQ-013 Port lt  output  1  A < B.

Function
REQ-014 The FSM SHALL have states IDLE and CMP; NSLICE = WIDTH/SLICE.
REQ-015 In IDLE with start=1, the block SHALL register a, b, signed_mode, set slice index to NSLICE-1, enter CMP and assert busy from the next cycle.
REQ-016 In IDLE with start=0, all state and outputs SHALL hold.
REQ-017 In CMP, each cycle SHALL compare slice[index] of A vs B, MSB slice first.
REQ-018 In signed mode, the top bit of both operands SHALL be inverted before the MSB-slice compare, making it unsigned.
REQ-019 If slices differ, the block SHALL set gt/lt accordingly with eq=0, pulse done, deassert busy and return to IDLE (early exit).
REQ-020 If slices are equal and index==0, the block SHALL set eq=1, gt=lt=0, pulse done and return to IDLE.
REQ-021 If slices are equal and index>0, the block SHALL decrement index and stay in CMP.
REQ-022 Latency from the start-accepting edge to done high SHALL be k cycles, k = number of slices examined (1..NSLICE).
REQ-023 Exactly one of gt/eq/lt SHALL be high after the first done; results SHALL hold until the next done.
REQ-024 gt/eq/lt SHALL be stable from the edge that raises done; they are not cleared when a new comparison starts.
REQ-025 start while busy=1 SHALL be ignored, as SHALL changes to a/b/signed_mode during CMP.
REQ-026 start high in the cycle done is high SHALL be accepted (back-to-back operation, no idle gap).

Reset
REQ-027 With rst_n=0 at a rising edge, state SHALL be IDLE, index 0, busy=0, done=0, gt=0, eq=0, lt=0.
REQ-028 Reset during CMP SHALL abandon the comparison with no done pulse.
REQ-029 start sampled while rst_n=0 SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, CMP) and the 3-bit result encoding {gt,eq,lt}.
REQ-031 One combinational sub-module mag_comp_slice (parameter SLICE; outputs gt/eq/lt) SHALL perform the per-slice compare and SHALL be the only arithmetic in the block.
REQ-032 Operand and index registers SHALL be sized from WIDTH/SLICE with no hard-coded widths.

Verification (WIDTH=16, SLICE=4)
REQ-033 Unsigned, A=0x1234, B=0x1234 -> done 4 cycles after start, eq=1, gt=lt=0, busy high 4 cycles.
REQ-034 A=0x8000, B=0x7FFF: unsigned -> gt=1, done after 1 cycle; signed -> lt=1, done after 1 cycle.
REQ-035 Unsigned, A=0x00F1, B=0x00F0 -> gt=1 after 4 cycles; swap operands -> lt=1 after 4 cycles.
REQ-036 Signed, A=0xFFFF, B=0xFFFE -> gt=1 after 4 cycles; A=0x0000, B=0xFFFF signed -> gt=1 after 1 cycle.
REQ-037 Control: start pulsed mid-CMP is ignored and the result is unchanged; start in the done cycle starts a new compare; rst_n=0 in the 2nd CMP cycle -> no done, all outputs 0.
REQ-038 Random: 10k random a/b/mode compared against a reference model; exactly one of gt/eq/lt high and latency per REQ-022 checked.

Source files
------------

// File: rtl/seq_mag_comp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state encoding,
// the one-hot {gt,eq,lt} result encoding and a small sizing helper.
package seq_mag_comp_pkg;

  // Controller states: waiting for a request, or walking slices MSB first
  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  // Result word packed as {gt, eq, lt}; exactly one bit set once valid
  typedef logic [2:0] result_t;

  localparam result_t RES_NONE = 3'b000;
  localparam result_t RES_GT   = 3'b100;
  localparam result_t RES_EQ   = 3'b010;
  localparam result_t RES_LT   = 3'b001;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_comp_slice.sv
// Combinational unsigned magnitude compare of one SLICE-bit operand slice.
// This is the only arithmetic in the comparator datapath.
module mag_comp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  // Straight unsigned relational compare; signedness is handled by the caller
  always_comb begin
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
  end

endmodule

// File: rtl/seq_mag_comp.sv
// Sequential magnitude comparator: compares two WIDTH-bit operands SLICE bits
// per clock, most significant slice first, stopping at the first slice that
// differs. Signed compares invert the operand sign bits on the top slice so
// the unsigned slice comparator gives the two's-complement ordering.
module seq_mag_comp
  import seq_mag_comp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = idxWidth(NSLICE);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = '0;
  localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic             r_signedMode;
  logic [IDX_W-1:0] r_index;
  logic             r_busy;
  logic             r_done;
  result_t          r_result;

  logic             w_flipMsb;
  logic [SLICE-1:0] w_sliceA;
  logic [SLICE-1:0] w_sliceB;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;

  // Operands shift left after every equal slice, so the slice under test is
  // always the top SLICE bits; the sign fix-up only applies to the first one.
  assign w_flipMsb = r_signedMode && (r_index == LAST_IDX);
  assign w_sliceA  = r_opA[WIDTH-1 -: SLICE] ^ (w_flipMsb ? MSB_MASK : '0);
  assign w_sliceB  = r_opB[WIDTH-1 -: SLICE] ^ (w_flipMsb ? MSB_MASK : '0);

  mag_comp_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a  (w_sliceA),
    .b  (w_sliceB),
    .gt (w_gt),
    .eq (w_eq),
    .lt (w_lt)
  );

  // Controller: capture operands on start, then resolve one slice per cycle
  // with early exit on the first difference; results persist until replaced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_opA        <= '0;
      r_opB        <= '0;
      r_signedMode <= 1'b0;
      r_index      <= ZERO_IDX;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= RES_NONE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_opA        <= a;
            r_opB        <= b;
            r_signedMode <= signed_mode;
            r_index      <= LAST_IDX;
            r_busy       <= 1'b1;
            r_state      <= CMP;
          end
        end
        CMP: begin
          if (!w_eq) begin
            r_result <= w_gt ? RES_GT : (w_lt ? RES_LT : RES_NONE);
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else if (r_index == ZERO_IDX) begin
            r_result <= RES_EQ;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_index <= r_index - 1'b1;
            r_opA   <= r_opA << SLICE;
            r_opB   <= r_opB << SLICE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign gt   = r_result[2];
  assign eq   = r_result[1];
  assign lt   = r_result[0];

endmodule
